// File: rtl/validready2noc_pkg.sv
// Shared types and helpers for the buffered valid/ready to NoC adapter.
// The defaults describe the standard 3-VC configuration.
package validready2noc_pkg;

    localparam int NocNumVcs      = 3;
    localparam int NocVcIdWidth   = 2;
    localparam int NocFlitWidth   = 64;
    localparam int NocBufferDepth = 4;
    localparam int PtrWidth       = $clog2(NocBufferDepth);

    // The arbiter helper works on a fixed wide mask so any VC count up to 32 can use it
    localparam int MaxVcs        = 32;
    localparam int MaxVcIdxWidth = 5;

    typedef logic [NocNumVcs-1:0] vc_mask_t;

    typedef struct packed {
        logic                     valid;
        logic [MaxVcIdxWidth-1:0] idx;
    } rr_grant_t;

    function automatic rr_grant_t rr_next(input logic [MaxVcIdxWidth-1:0] p,
                                          input logic [MaxVcs-1:0]        eligible,
                                          input int                       n);
        rr_grant_t g;
        int        cand;
        g = '0;
        for (int i = 0; i < MaxVcs; i++) begin
            if (i < n) begin
                cand = int'(p) + i;
                if (cand >= n) cand = cand - n;
                if (!g.valid && eligible[cand[MaxVcIdxWidth-1:0]]) begin
                    g.valid = 1'b1;
                    g.idx   = cand[MaxVcIdxWidth-1:0];
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/validready2noc_buffered_adapter_fifo.sv
// One per-VC synchronous FIFO; head is read combinationally, count drives full/empty.
module noc_vc_fifo
    import validready2noc_pkg::*;
#(
    parameter int Width = NocFlitWidth,
    parameter int Depth = NocBufferDepth
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [Width-1:0]           data_i,
    output logic [Width-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     count_o
);

    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PW'(push_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_i);
        count_d  = count_q + CW'(push_i) - CW'(pop_i);
        if (push_i) mem_d[wr_ptr_q] = data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/validready2noc_buffered_adapter.sv
// Per-VC buffered valid/ready to NoC avail/valid adapter with a round-robin
// output arbiter; one flit in and at most one flit out per cycle.
module validready2noc_buffered_adapter
    import validready2noc_pkg::*;
#(
    parameter int NumberOfVirtualChannels = NocNumVcs,
    parameter int VirtualChannelIdWidth   = NocVcIdWidth,
    parameter int FlitWidth               = NocFlitWidth,
    parameter int BufferDepth             = NocBufferDepth
) (
    input  logic                                                      clk_i,
    input  logic                                                      rst_i,
    input  logic                                                      valid_i,
    output logic                                                      ready_o,
    input  logic [VirtualChannelIdWidth-1:0]                          virtual_channel_id_i,
    input  logic [FlitWidth-1:0]                                      data_i,
    output logic [NumberOfVirtualChannels-1:0]                        valid_o,
    output logic [FlitWidth-1:0]                                      data_o,
    input  logic [NumberOfVirtualChannels-1:0]                        avail_i,
    output logic [NumberOfVirtualChannels*($clog2(BufferDepth)+1)-1:0] occupancy_o,
    output logic                                                      error_o
);

    localparam int N          = NumberOfVirtualChannels;
    localparam int CntWidth   = $clog2(BufferDepth) + 1;
    localparam int VcIdxWidth = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]          push, pop, full, empty, eligible, grant;
    logic [FlitWidth-1:0]  head [N];
    logic [CntWidth-1:0]   count [N];
    logic [VcIdxWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [FlitWidth-1:0]  data_q, data_d;
    logic                  error_q, error_d;
    logic                  id_in_range;
    rr_grant_t             rr;

    // Ready looks only at registered fill level, so a pop never re-opens a full VC in the same cycle
    always_comb begin
        ready_o     = 1'b0;
        push        = '0;
        id_in_range = (int'(virtual_channel_id_i) < N);
        for (int v = 0; v < N; v++) begin
            if (virtual_channel_id_i == VirtualChannelIdWidth'(v)) begin
                ready_o = !rst_i && !full[v];
                push[v] = valid_i && !rst_i && !full[v];
            end
        end
        error_d = error_q | (valid_i && !id_in_range);
    end

    always_comb begin
        eligible = ~empty & avail_i;
        rr       = rr_next(MaxVcIdxWidth'(rr_ptr_q), MaxVcs'(eligible), N);
        grant    = '0;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        for (int v = 0; v < N; v++) begin
            if (rr.valid && rr.idx == MaxVcIdxWidth'(v)) begin
                grant[v] = 1'b1;
                data_d   = head[v];
                rr_ptr_d = (v == N - 1) ? '0 : VcIdxWidth'(v + 1);
            end
        end
        pop = grant;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            data_q   <= '0;
            error_q  <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            error_q  <= error_d;
        end
    end

    for (genvar v = 0; v < N; v++) begin : g_vc
        noc_vc_fifo #(
            .Width (FlitWidth),
            .Depth (BufferDepth)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push[v]),
            .pop_i   (pop[v]),
            .data_i  (data_i),
            .data_o  (head[v]),
            .full_o  (full[v]),
            .empty_o (empty[v]),
            .count_o (count[v])
        );
        assign occupancy_o[v*CntWidth +: CntWidth] = count[v];
    end

    // Idle cycles keep presenting the last transferred flit
    assign valid_o = grant;
    assign data_o  = data_d;
    assign error_o = error_q;

    a_onehot:    assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(valid_o));
    a_avail:     assert property (@(posedge clk_i) disable iff (rst_i) (valid_o & ~avail_i) == '0);
    a_push_full: assert property (@(posedge clk_i) disable iff (rst_i) (push & full) == '0);
    a_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) (pop & empty) == '0);

endmodule

// File: tb/tb_validready2noc_buffered_adapter.sv
// Scoreboard bench for the buffered adapter: per-VC expected queues filled on
// accepted offers, drained and compared whenever the DUT presents a flit.
module tb_validready2noc_buffered_adapter;
    import validready2noc_pkg::*;

    localparam int N  = 3;
    localparam int IW = 2;
    localparam int FW = 64;
    localparam int D  = 4;
    localparam int CW = 3;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            valid_i;
    logic            ready_o;
    logic [IW-1:0]   vc_id;
    logic [FW-1:0]   data_i;
    vc_mask_t        valid_o;
    logic [FW-1:0]   data_o;
    vc_mask_t        avail_i;
    logic [N*CW-1:0] occupancy_o;
    logic            error_o;

    always #5 clk_i = ~clk_i;

    validready2noc_buffered_adapter #(
        .NumberOfVirtualChannels (N),
        .VirtualChannelIdWidth   (IW),
        .FlitWidth               (FW),
        .BufferDepth             (D)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .valid_i              (valid_i),
        .ready_o              (ready_o),
        .virtual_channel_id_i (vc_id),
        .data_i               (data_i),
        .valid_o              (valid_o),
        .data_o               (data_o),
        .avail_i              (avail_i),
        .occupancy_o          (occupancy_o),
        .error_o              (error_o)
    );

    int          checks = 0;
    int          errors = 0;
    logic [FW-1:0] sb [N][$];
    int          grant_log [$];
    logic [FW-1:0] last_data = '0;
    logic        err_model = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, update model at posedge
    task automatic step(input logic v, input logic [IW-1:0] id, input logic [FW-1:0] d,
                        input vc_mask_t av);
        logic exp_ready;
        logic any_elig;
        int   g;
        valid_i = v;
        vc_id   = id;
        data_i  = d;
        avail_i = av;
        @(negedge clk_i);
        exp_ready = 1'b0;
        if (int'(id) < N) exp_ready = (sb[id].size() < D);
        chk("ready", ready_o, exp_ready);
        chk("error", error_o, err_model);
        for (int k = 0; k < N; k++)
            chk($sformatf("occ_vc%0d", k), occupancy_o[k*CW +: CW], sb[k].size());
        any_elig = 1'b0;
        for (int k = 0; k < N; k++)
            if (sb[k].size() > 0 && av[k]) any_elig = 1'b1;
        chk("valid_any", |valid_o, any_elig);
        if (valid_o == '0) begin
            chk("data_hold", data_o, last_data);
        end else begin
            chk("onehot", $onehot(valid_o), 1);
            chk("valid_avail", valid_o & ~av, 0);
            g = 0;
            for (int k = 0; k < N; k++) if (valid_o[k]) g = k;
            grant_log.push_back(g);
            chk("sb_nonempty", sb[g].size() > 0, 1);
            if (sb[g].size() > 0) begin
                last_data = sb[g].pop_front();
                chk($sformatf("data_vc%0d", g), data_o, last_data);
            end
        end
        if (v && exp_ready) sb[id].push_back(d);
        @(posedge clk_i);
        if (v && int'(id) >= N) err_model = 1'b1;
        #1;
    endtask

    task automatic check_log(input string tag, input int exp []);
        chk({tag, "_len"}, grant_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
            chk($sformatf("%s_%0d", tag, i), grant_log[i], exp[i]);
        grant_log.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_ready"}, ready_o, 0);
        chk({tag, "_occ"}, occupancy_o, 0);
        chk({tag, "_data"}, data_o, 0);
        chk({tag, "_error"}, error_o, 0);
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) sb[k].delete();
        grant_log.delete();
        last_data = '0;
        err_model = 1'b0;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b1;
        vc_id   = '0;
        data_i  = 64'h1234;
        avail_i = 3'b111;
        #2;
        check_reset_outputs("por");
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;

        // single flit
        step(1'b1, 2'd1, 64'hA5, 3'b111);
        step(1'b0, 2'd0, 64'h0, 3'b111);
        step(1'b0, 2'd0, 64'h0, 3'b111);
        check_log("single", '{1});

        // fill VC0, backpressure, pop re-opens ready one cycle later
        for (int i = 0; i < D; i++) step(1'b1, 2'd0, 64'h100 + i, 3'b000);
        step(1'b1, 2'd0, 64'hDEAD, 3'b000);
        step(1'b1, 2'd2, 64'h200, 3'b000);
        step(1'b1, 2'd0, 64'h104, 3'b001);
        step(1'b1, 2'd0, 64'h104, 3'b001);
        repeat (10) step(1'b0, 2'd0, 64'h0, 3'b111);
        for (int k = 0; k < N; k++) chk($sformatf("drained_vc%0d", k), sb[k].size(), 0);
        grant_log.delete();
        // leave the pointer at VC0 by making VC2 the last grant
        step(1'b1, 2'd2, 64'h2F, 3'b000);
        step(1'b0, 2'd0, 64'h0, 3'b100);
        check_log("park", '{2});

        // round-robin fairness
        for (int v = 0; v < N; v++)
            for (int k = 0; k < 2; k++) step(1'b1, IW'(v), 64'h300 + v*16 + k, 3'b000);
        repeat (6) step(1'b0, 2'd0, 64'h0, 3'b111);
        check_log("rr", '{0, 1, 2, 0, 1, 2});

        // blocked VC1 must not stall VC2
        for (int k = 0; k < D; k++) step(1'b1, 2'd1, 64'h410 + k, 3'b000);
        for (int k = 0; k < 3; k++) step(1'b1, 2'd2, 64'h420 + k, 3'b000);
        repeat (3) step(1'b0, 2'd0, 64'h0, 3'b101);
        check_log("iso_vc2", '{2, 2, 2});
        repeat (5) step(1'b0, 2'd0, 64'h0, 3'b111);
        check_log("iso_vc1", '{1, 1, 1, 1});

        // out-of-range id sets a sticky error and writes nothing
        step(1'b1, 2'd3, 64'hBAD, 3'b111);
        repeat (3) step(1'b0, 2'd0, 64'h0, 3'b111);
        chk("error_sticky", error_o, 1);
        grant_log.delete();

        // asynchronous reset with flits buffered
        step(1'b1, 2'd0, 64'h700, 3'b000);
        step(1'b1, 2'd1, 64'h701, 3'b000);
        step(1'b1, 2'd2, 64'h702, 3'b000);
        avail_i = 3'b111;
        valid_i = 1'b1;
        vc_id   = 2'd0;
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        clear_model();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (3) step(1'b0, 2'd0, 64'h0, 3'b111);
        check_log("no_stale", '{});
        step(1'b1, 2'd1, 64'hA5, 3'b111);
        step(1'b0, 2'd0, 64'h0, 3'b111);
        step(1'b0, 2'd0, 64'h0, 3'b111);
        check_log("post_rst", '{1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
